// File: rtl/dmem_ctrl.sv
// Data-memory request controller: holds MEM-stage requests toward the data cache and registers extended load data.
// Optional cache-wait timeout is compiled in with `define DMEM_TIMEOUT_EN (limit = TIMEOUT_CYCLES).
module dmem_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_read,
    input  logic        dmem_write,
    input  logic [31:0] dmem_address,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  mem_byte_enable,
    input  logic [2:0]  load_funct3,
    input  logic [1:0]  addr_lo,
    output logic        mem_stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        load_misaligned,
    output logic        dmem_err,
    output logic        cache_read,
    output logic        cache_write,
    output logic [31:0] cache_address,
    output logic [31:0] cache_wdata,
    output logic [3:0]  cache_mbe,
    input  logic        cache_resp,
    input  logic [31:0] cache_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    state_t      state;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_mbe;
    logic [2:0]  req_funct3;
    logic [1:0]  req_lo;
    logic        req_write;
    logic        req_valid;
    logic        misaligned_now;

    function automatic logic [31:0] extract_load(input logic [2:0]  f3,
                                                 input logic [1:0]  lo,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_LB:   return {{24{b[7]}}, b};
            F3_LH:   return {{16{h[15]}}, h};
            F3_LBU:  return {24'h0, b};
            F3_LHU:  return {16'h0, h};
            default: return word;
        endcase
    endfunction

    assign req_valid = dmem_read | dmem_write;

    // Stores are never checked; a read+write request counts as a store.
    assign misaligned_now = !dmem_write &&
                            (((load_funct3 == F3_LW) && (addr_lo != 2'b00)) ||
                             (((load_funct3 == F3_LH) || (load_funct3 == F3_LHU)) && addr_lo[0]));

    // NOTE: the stall must rise in the same cycle the request appears, so it is decoded from
    // state and request inputs rather than registered; every path assigns it, so no latch.
    always_comb begin
        mem_stall = (state == S_WAIT) || ((state == S_IDLE) && req_valid);
    end

    assign cache_read    = (state == S_WAIT) && !req_write;
    assign cache_write   = (state == S_WAIT) && req_write;
    assign cache_address = req_addr;
    assign cache_wdata   = req_wdata;
    assign cache_mbe     = req_mbe;

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] wait_cnt;
`else
    assign dmem_err = 1'b0;
`endif

    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values; the async reset clears the request copy too, so no X reaches the cache.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            req_addr        <= '0;
            req_wdata       <= '0;
            req_mbe         <= '0;
            req_funct3      <= '0;
            req_lo          <= '0;
            req_write       <= 1'b0;
            load_data       <= '0;
            load_valid      <= 1'b0;
            load_misaligned <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            dmem_err        <= 1'b0;
            wait_cnt        <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    load_valid      <= 1'b0;
                    load_misaligned <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
                    dmem_err        <= 1'b0;
`endif
                    if (req_valid) begin
                        req_addr   <= dmem_address;
                        req_wdata  <= dmem_wdata;
                        req_mbe    <= mem_byte_enable;
                        req_funct3 <= load_funct3;
                        req_lo     <= addr_lo;
                        req_write  <= dmem_write;
                        if (misaligned_now) begin
                            load_data       <= '0;
                            load_valid      <= 1'b1;
                            load_misaligned <= 1'b1;
                            state           <= S_DONE;
                        end else begin
`ifdef DMEM_TIMEOUT_EN
                            wait_cnt <= '0;
`endif
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cache_resp) begin
                        load_data  <= req_write ? 32'h0 : extract_load(req_funct3, req_lo, cache_rdata);
                        load_valid <= 1'b1;
                        state      <= S_DONE;
                    end
`ifdef DMEM_TIMEOUT_EN
                    else if (wait_cnt == CNT_LAST) begin
                        load_data  <= '0;
                        load_valid <= 1'b1;
                        dmem_err   <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end
                S_DONE: begin
                    load_valid      <= 1'b0;
                    load_misaligned <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
                    dmem_err        <= 1'b0;
`endif
                    state           <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl; inputs change on the falling edge, outputs are sampled 1ns later.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [31:0] dmem_wdata;
    logic [3:0]  mem_byte_enable;
    logic [2:0]  load_funct3;
    logic [1:0]  addr_lo;
    logic        mem_stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        load_misaligned;
    logic        dmem_err;
    logic        cache_read;
    logic        cache_write;
    logic [31:0] cache_address;
    logic [31:0] cache_wdata;
    logic [3:0]  cache_mbe;
    logic        cache_resp;
    logic [31:0] cache_rdata;

    int checks   = 0;
    int failures = 0;

    dmem_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .dmem_read       (dmem_read),
        .dmem_write      (dmem_write),
        .dmem_address    (dmem_address),
        .dmem_wdata      (dmem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .load_funct3     (load_funct3),
        .addr_lo         (addr_lo),
        .mem_stall       (mem_stall),
        .load_data       (load_data),
        .load_valid      (load_valid),
        .load_misaligned (load_misaligned),
        .dmem_err        (dmem_err),
        .cache_read      (cache_read),
        .cache_write     (cache_write),
        .cache_address   (cache_address),
        .cache_wdata     (cache_wdata),
        .cache_mbe       (cache_mbe),
        .cache_resp      (cache_resp),
        .cache_rdata     (cache_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Full load: request in cycle 0, cache_resp in WAIT cycle resp_cycle, then DONE and one IDLE cycle.
    task automatic load_txn(input string tag, input logic [2:0] f3, input logic [1:0] lo,
                            input logic [31:0] addr, input logic [31:0] rdata,
                            input int resp_cycle, input logic [31:0] exp_data);
        int stalls;
        step();
        dmem_read = 1'b1; dmem_address = addr; load_funct3 = f3; addr_lo = lo;
        #1;
        check({tag, "_stall_c0"}, mem_stall, 1'b1);
        check({tag, "_rd_c0"}, cache_read, 1'b0);
        stalls = int'(mem_stall);
        for (int i = 1; i <= resp_cycle; i++) begin
            step();
            dmem_read = 1'b0; dmem_address = 32'hFFFF_FFF0; load_funct3 = 3'b111; addr_lo = 2'b01;
            cache_resp  = (i == resp_cycle);
            cache_rdata = rdata;
            #1;
            check({tag, "_rd_wait"}, cache_read, 1'b1);
            check({tag, "_addr_wait"}, cache_address, addr);
            stalls += int'(mem_stall);
        end
        step();
        cache_resp = 1'b0; cache_rdata = 32'h5A5A_5A5A;
        #1;
        check({tag, "_valid_done"}, load_valid, 1'b1);
        check({tag, "_data_done"}, load_data, exp_data);
        check({tag, "_stall_done"}, mem_stall, 1'b0);
        check({tag, "_rd_done"}, cache_read, 1'b0);
        check({tag, "_err_done"}, dmem_err, 1'b0);
        check({tag, "_mis_done"}, load_misaligned, 1'b0);
        check({tag, "_stall_cycles"}, stalls, resp_cycle + 1);
        step();
        #1;
        check({tag, "_valid_idle"}, load_valid, 1'b0);
        check({tag, "_data_hold"}, load_data, exp_data);
    endtask

    task automatic misaligned_txn(input string tag, input logic [2:0] f3, input logic [1:0] lo);
        step();
        dmem_read = 1'b1; dmem_address = 32'h0000_0040; load_funct3 = f3; addr_lo = lo;
        cache_resp = 1'b1; cache_rdata = 32'h1234_5678;
        #1;
        check({tag, "_stall_c0"}, mem_stall, 1'b1);
        step();
        dmem_read = 1'b0;
        #1;
        check({tag, "_valid"}, load_valid, 1'b1);
        check({tag, "_mis"}, load_misaligned, 1'b1);
        check({tag, "_data"}, load_data, 32'h0);
        check({tag, "_rd"}, cache_read, 1'b0);
        check({tag, "_stall"}, mem_stall, 1'b0);
        step();
        cache_resp = 1'b0;
        #1;
        check({tag, "_mis_clear"}, load_misaligned, 1'b0);
        check({tag, "_rd_idle"}, cache_read, 1'b0);
    endtask

    initial begin
        #100000;
        $error("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        dmem_read = 1'b0; dmem_write = 1'b0; dmem_address = '0; dmem_wdata = '0;
        mem_byte_enable = '0; load_funct3 = '0; addr_lo = '0; cache_resp = 1'b0; cache_rdata = '0;

        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_stall", mem_stall, 1'b0);
        check("rst_data", load_data, 32'h0);
        check("rst_valid", load_valid, 1'b0);
        check("rst_mis", load_misaligned, 1'b0);
        check("rst_err", dmem_err, 1'b0);
        check("rst_rd", cache_read, 1'b0);
        check("rst_wr", cache_write, 1'b0);

        // Idle cycle without a request: no stall.
        step();
        #1;
        check("idle_stall", mem_stall, 1'b0);

        load_txn("lw",  3'b010, 2'd0, 32'h0000_0100, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF);
        load_txn("lb",  3'b000, 2'd3, 32'h0000_0104, 32'h80FF_FFFF, 1, 32'hFFFF_FF80);
        load_txn("lbu", 3'b100, 2'd3, 32'h0000_0104, 32'h80FF_FFFF, 1, 32'h0000_0080);
        load_txn("lh",  3'b001, 2'd2, 32'h0000_0108, 32'h8001_1234, 2, 32'hFFFF_8001);
        load_txn("lhu", 3'b101, 2'd0, 32'h0000_0108, 32'h8001_9234, 1, 32'h0000_9234);
        load_txn("f3u", 3'b111, 2'd0, 32'h0000_010C, 32'h0BAD_F00D, 1, 32'h0BAD_F00D);

        // sh with read also asserted: must be handled as a store with held fields.
        step();
        dmem_read = 1'b1; dmem_write = 1'b1; dmem_address = 32'h0000_0200;
        dmem_wdata = 32'hABCD_0000; mem_byte_enable = 4'b1100; load_funct3 = 3'b001; addr_lo = 2'd2;
        #1;
        check("sh_stall_c0", mem_stall, 1'b1);
        for (int i = 1; i <= 2; i++) begin
            step();
            dmem_read = 1'b0; dmem_write = 1'b0; dmem_address = 32'h0000_0300;
            dmem_wdata = 32'h1111_2222; mem_byte_enable = 4'b0011;
            cache_resp = (i == 2); cache_rdata = 32'h1234_5678;
            #1;
            check("sh_wr", cache_write, 1'b1);
            check("sh_rd", cache_read, 1'b0);
            check("sh_addr", cache_address, 32'h0000_0200);
            check("sh_wdata", cache_wdata, 32'hABCD_0000);
            check("sh_mbe", cache_mbe, 4'b1100);
            check("sh_stall", mem_stall, 1'b1);
        end
        step();
        cache_resp = 1'b0;
        #1;
        check("sh_valid", load_valid, 1'b1);
        check("sh_data", load_data, 32'h0);
        check("sh_wr_done", cache_write, 1'b0);
        check("sh_stall_done", mem_stall, 1'b0);

        misaligned_txn("mis_lw", 3'b010, 2'd2);
        misaligned_txn("mis_lh", 3'b001, 2'd3);

        load_txn("lw_pre_rst", 3'b010, 2'd0, 32'h0000_0400, 32'hCAFE_0001, 1, 32'hCAFE_0001);

        // Reset asserted mid-WAIT.
        step();
        dmem_read = 1'b1; dmem_address = 32'h0000_0500; load_funct3 = 3'b010; addr_lo = 2'd0;
        step();
        dmem_read = 1'b0;
        #1;
        check("rstw_rd_before", cache_read, 1'b1);
        rst = 1'b1;
        #1;
        check("rstw_rd", cache_read, 1'b0);
        check("rstw_stall", mem_stall, 1'b0);
        check("rstw_data", load_data, 32'h0);
        step();
        rst = 1'b0;
        #1;
        check("rstw_idle_stall", mem_stall, 1'b0);
        load_txn("lw_post_rst", 3'b010, 2'd0, 32'h0000_0600, 32'h7654_3210, 2, 32'h7654_3210);

`ifdef DMEM_TIMEOUT_EN
        // No response: four WAIT cycles, then DONE with an error.
        step();
        dmem_read = 1'b1; dmem_address = 32'h0000_0700; load_funct3 = 3'b010; addr_lo = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            step();
            dmem_read = 1'b0;
            #1;
            check("to_rd_wait", cache_read, 1'b1);
        end
        step();
        #1;
        check("to_err", dmem_err, 1'b1);
        check("to_valid", load_valid, 1'b1);
        check("to_data", load_data, 32'h0);
        check("to_rd_done", cache_read, 1'b0);
        step();
        #1;
        check("to_err_clear", dmem_err, 1'b0);
        // Response in the fourth WAIT cycle wins over expiry.
        load_txn("to_resp_last", 3'b010, 2'd0, 32'h0000_0704, 32'h0123_4567, 4, 32'h0123_4567);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
